// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder_new built-in self-test.
package adder_bist_pkg;
  localparam int DEF_WIDTH = 6;
  localparam int SETTLE_W  = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  function automatic int num_vectors(input int w);
    return 1 << (2 * w);
  endfunction

  localparam int NUM_VECTORS = num_vectors(DEF_WIDTH);
endpackage

// File: rtl/adder_bist_if.sv
// Operand/result bundle between the BIST stage and the adder under test.
interface adder_bist_if #(parameter int WIDTH = 6);
  logic [WIDTH-1:0] x_o;
  logic [WIDTH-1:0] y_o;
  logic [WIDTH-1:0] s_i;
  logic             cout_i;

  modport master (output x_o, y_o, input s_i, cout_i);
  modport slave  (input x_o, y_o, output s_i, cout_i);
endinterface

// File: rtl/adder_bist_sat_counter.sv
// Saturating incrementer with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst || clr)             count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/adder_bist.sv
// Exhaustive self-test of the adder: walks every {x,y} pair, compares against a
// reference sum, counts mismatches and records the first failing vector.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  adder_bist_if.master       adr,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               err_pulse,
  output logic               first_err_valid,
  output logic [2*WIDTH-1:0] first_err_idx
);
  localparam logic [2*WIDTH-1:0]  LAST_IDX    = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [2*WIDTH-1:0]   idx;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [WIDTH:0]       ref_sum;
  logic                 mismatch;
  logic                 run_start;

  assign adr.x_o = idx[2*WIDTH-1:WIDTH];
  assign adr.y_o = idx[WIDTH-1:0];

  assign ref_sum   = {1'b0, adr.x_o} + {1'b0, adr.y_o};
  assign mismatch  = (state == CHECK) && ({adr.cout_i, adr.s_i} != ref_sum);
  assign run_start = start && (state == IDLE || state == DONE);
  assign pass      = done && (err_count == '0);

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_start),
    .inc   (mismatch),
    .count (err_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      settle_cnt      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_pulse       <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      err_pulse <= mismatch;
      case (state)
        IDLE, DONE: begin
          // DONE holds results and the last operands until the next start.
          if (start) begin
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            done            <= 1'b0;
            idx             <= '0;
            settle_cnt      <= '0;
            busy            <= 1'b1;
            state           <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= CHECK;
          else                           settle_cnt <= settle_cnt + 1'b1;
        end
        CHECK: begin
          if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= idx;
          end
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx        <= idx + 1'b1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_bist.sv
// Directed bench: two BIST instances (settle 1 and 3) against behavioural adder models.
module tb_adder_bist;
  logic clk = 1'b0;
  logic rst;
  logic start1, start3;
  logic [1:0] mode;

  logic        busy1, done1, pass1, pulse1, fev1;
  logic [31:0] err1;
  logic [11:0] fei1;
  logic        busy3, done3, pass3, pulse3, fev3;
  logic [31:0] err3;
  logic [11:0] fei3;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  adder_bist_if #(.WIDTH(6)) ifc1 ();
  adder_bist_if #(.WIDTH(6)) ifc3 ();

  adder_bist #(.WIDTH(6), .SETTLE_CYCLES(1), .ERR_W(32)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .adr(ifc1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .err_pulse(pulse1), .first_err_valid(fev1), .first_err_idx(fei1));

  adder_bist #(.WIDTH(6), .SETTLE_CYCLES(3), .ERR_W(32)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .adr(ifc3.master),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .err_pulse(pulse3), .first_err_valid(fev3), .first_err_idx(fei3));

  // Adder models: 0 golden, 1 S[0] stuck-0, 2 cout stuck-0, 3 two-cycle lag
  logic [6:0] g1, g3, m1, lag1a, lag1b, lag3a, lag3b;
  assign g1 = {1'b0, ifc1.x_o} + {1'b0, ifc1.y_o};
  assign g3 = {1'b0, ifc3.x_o} + {1'b0, ifc3.y_o};

  always @(posedge clk) begin
    lag1a <= g1; lag1b <= lag1a;
    lag3a <= g3; lag3b <= lag3a;
  end

  always_comb begin
    m1 = g1;
    case (mode)
      2'd1: m1[0] = 1'b0;
      2'd2: m1[6] = 1'b0;
      2'd3: m1 = lag1b;
      default: ;
    endcase
  end

  assign ifc1.s_i    = m1[5:0];
  assign ifc1.cout_i = m1[6];
  assign ifc3.s_i    = lag3b[5:0];
  assign ifc3.cout_i = lag3b[6];

  always @(negedge clk) if (pulse1 === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start on dut1, then count edges until done (start-sampling edge is edge 0).
  task automatic run1(input string tag, output int lat);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check({tag, "_busy"}, busy1, 1);
    lat = 0;
    for (int n = 1; n <= 10000; n++) begin
      @(posedge clk); #1;
      if (done1) begin lat = n; break; end
    end
    @(negedge clk);
  endtask

  task automatic wait_idx1(input int target, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if ({ifc1.x_o, ifc1.y_o} == 12'(target)) begin ok = 1'b1; break; end
    end
  endtask

  int lat, lat1, lat3, base;
  bit ok;

  initial begin
    mode = 2'd0; rst = 1'b1; start1 = 1'b1; start3 = 1'b1;

    // 1: reset with start held high
    repeat (3) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_pulse", pulse1, 0);
    check("rst_err", err1, 0);
    check("rst_fev", fev1, 0);
    check("rst_fei", fei1, 0);
    check("rst_x", ifc1.x_o, 0);
    check("rst_y", ifc1.y_o, 0);
    check("rst_busy3", busy3, 0);
    start1 = 1'b0; start3 = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy1, 0);

    // 2: golden run
    base = pulse_cnt;
    run1("t2", lat);
    check("t2_lat", lat, 8192);
    check("t2_done", done1, 1);
    check("t2_pass", pass1, 1);
    check("t2_busy", busy1, 0);
    check("t2_err", err1, 0);
    check("t2_fev", fev1, 0);
    check("t2_pulses", pulse_cnt - base, 0);
    check("t2_hold_x", ifc1.x_o, 63);
    check("t2_hold_y", ifc1.y_o, 63);

    // 3: S[0] stuck at 0, restart from DONE
    mode = 2'd1;
    base = pulse_cnt;
    run1("t3", lat);
    check("t3_lat", lat, 8192);
    check("t3_err", err1, 2048);
    check("t3_fev", fev1, 1);
    check("t3_fei", fei1, 1);
    check("t3_pass", pass1, 0);
    check("t3_pulses", pulse_cnt - base, 2048);

    // 4: cout stuck at 0
    mode = 2'd2;
    run1("t4", lat);
    check("t4_err", err1, 2016);
    check("t4_fei", fei1, 127);
    check("t4_fev", fev1, 1);
    check("t4_pass", pass1, 0);

    // 5: start while busy is ignored, mid-run reset aborts
    mode = 2'd0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_idx1(100, ok);
    check("t5_reach100", ok, 1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_idx_cont", {ifc1.x_o, ifc1.y_o}, 102);
    check("t5_busy", busy1, 1);
    check("t5_err_clr", err1, 0);
    wait_idx1(200, ok);
    check("t5_reach200", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_x", ifc1.x_o, 0);
    check("t5_rst_y", ifc1.y_o, 0);
    check("t5_rst_busy", busy1, 0);
    check("t5_rst_done", done1, 0);
    check("t5_rst_pass", pass1, 0);
    run1("t5", lat);
    check("t5_lat", lat, 8192);
    check("t5_pass", pass1, 1);

    // 6: lagging adder, settle 3 passes, settle 1 fails
    mode = 2'd3;
    start1 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    lat1 = 0; lat3 = 0;
    for (int n = 1; n <= 20000; n++) begin
      @(posedge clk); #1;
      if (done1 && lat1 == 0) lat1 = n;
      if (done3 && lat3 == 0) lat3 = n;
      if (lat1 != 0 && lat3 != 0) break;
    end
    @(negedge clk);
    check("t6_lat3", lat3, 16384);
    check("t6_pass3", pass3, 1);
    check("t6_err3", err3, 0);
    check("t6_fev3", fev3, 0);
    check("t6_lat1", lat1, 8192);
    check("t6_pass1", pass1, 0);
    check("t6_err1_nz", err1 != 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
Built-in self-test stage for the 6-bit `adder_new` block. It drives `adder_new` exhaustively through every X/Y operand pair and consumes its S/cout outputs, so it sits directly upstream and downstream of `adder_new`. It compares each result against an internally computed reference sum, counts mismatches and records the first failing vector. This gives an on-chip equivalent of the file-driven vector check, for use after synthesis/placement.

Parameters:
- WIDTH, 6: operand width; must match the adder under test.
- SETTLE_CYCLES, 1: clock cycles allowed for the adder output to settle before sampling; legal values are 1 to 15.
- ERR_W, 32: width of the error counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled; begins a run when sampled in IDLE or DONE.
- x_o  out  WIDTH  operand X to the adder (upper half of the vector index).
- y_o  out  WIDTH  operand Y to the adder (lower half of the vector index).
- s_i  in  WIDTH  adder sum S.
- cout_i  in  1  adder carry out.
- busy  out  1  high while a run is in progress.
- done  out  1  high from the end of a run until the next start or reset.
- pass  out  1  equals done AND (err_count == 0).
- err_count  out  ERR_W  number of mismatches; saturates at all-ones.
- err_pulse  out  1  one-cycle pulse on the cycle after each mismatching compare.
- first_err_valid  out  1  set at the first mismatch of a run.
- first_err_idx  out  2*WIDTH  vector index of the first mismatch, 0-based, equal to {x,y}.

Behaviour:
- Reset values:
  - idx = 0, so x_o = 0 and y_o = 0.
  - busy = 0, done = 0, pass = 0, err_pulse = 0.
  - err_count = 0, first_err_valid = 0, first_err_idx = 0.
  - State = IDLE.
  - Reset mid-run aborts immediately; the next cycle shows reset values, with no partial results retained.
- Operand mapping: {x_o, y_o} = idx, with both halves driven directly from the idx register. Vector order is x-major: idx 0 = (0,0), idx 1 = (0,1), ..., idx 4095 = (63,63).
- IDLE state:
  - On start=1: clear err_count, first_err_valid, first_err_idx and done; set idx = 0 and settle_cnt = 0; go to SETTLE; busy = 1.
- SETTLE state:
  - If settle_cnt == SETTLE_CYCLES-1, go to CHECK.
  - Otherwise increment settle_cnt.
- CHECK state:
  - Compare {cout_i, s_i} against the (WIDTH+1)-bit zero-extended sum x_o + y_o.
  - On mismatch:
    - err_count increments, saturating.
    - err_pulse = 1 on the next cycle.
    - If first_err_valid = 0, capture first_err_idx = idx and set first_err_valid.
  - If idx == 2^(2*WIDTH)-1: go to DONE; busy = 0, done = 1.
  - Otherwise: idx increments, settle_cnt = 0, return to SETTLE.
- DONE state:
  - Results and x_o/y_o hold (idx stays at the last vector).
  - start=1 restarts exactly as from IDLE.
- Latency:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - Counting the edge that samples start as edge 0, done is first visible after edge 4096*(SETTLE_CYCLES+1). For the default this is edge 8192.
- start while busy: ignored; the run continues unaffected.
- start held high continuously: one run occurs, followed by an immediate restart in the cycle after DONE is entered. Consumers must pulse start.
- Simultaneous rst and start: rst wins.
- err_count saturation: holds at 2^ERR_W-1 with no wrap. first_err fields are never overwritten within a run.

Decomposition:
- Package adder_bist_pkg holds:
  - The state enum (IDLE, SETTLE, CHECK, DONE).
  - Default WIDTH = 6.
  - NUM_VECTORS = 2^(2*WIDTH).
  - The settle counter width (4 bits).
- One natural sub-module: sat_counter, a saturating ERR_W-bit incrementer with synchronous clear. Everything else (FSM, idx, comparator) stays in adder_bist.

Test Plan:
1. Reset: assert rst for 3 cycles with start=1 → all outputs at reset values; x_o=0, y_o=0; no run starts while rst is high.
2. Golden adder_new, SETTLE_CYCLES=1, one-cycle start pulse → busy=1 next cycle; done=1 and pass=1 after edge 8192; err_count=0; first_err_valid=0; no err_pulse seen.
3. Adder model with S[0] stuck at 0 → err_count=2048; first_err_idx=1 (x=0, y=1); pass=0; err_pulse count equals 2048.
4. Adder model with cout stuck at 0 → err_count=2016; first_err_idx=127 (x=1, y=63).
5. Golden adder: start pulse at idx 100 is ignored; rst at idx 200 returns reset values next cycle; a fresh start then runs from idx 0 to pass=1.
6. SETTLE_CYCLES=3 with an adder model whose outputs lag by 2 cycles → pass=1 with done at edge 16384. The same model with SETTLE_CYCLES=1 → pass=0 and err_count > 0.
